// File: rtl/chaos_loader_pkg.sv
// Shared definitions for the chaos automaton configuration-chain loader.
// The optional feature macro CHAOS_LOADER_READBACK_EN is consumed by chaos_loader_ctrl.
package chaos_loader_pkg;

    localparam logic [1:0] OP_READ   = 2'b00;
    localparam logic [1:0] OP_WRITE  = 2'b01;
    localparam logic [1:0] OP_FINISH = 2'b10;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SEEK,
        ST_XFER,
        ST_RESTORE,
        ST_LATCH
    } state_e;

    // Operand width for modsub; callers zero-extend cell indices into it.
    localparam int unsigned MODSUB_W = 16;

    // (a - b) mod n for a, b < n: one extra bit catches the borrow, then a
    // conditional add of n folds a negative difference back into range.
    function automatic logic [MODSUB_W-1:0] modsub(
        input logic [MODSUB_W-1:0] a,
        input logic [MODSUB_W-1:0] b,
        input logic [MODSUB_W-1:0] n
    );
        logic [MODSUB_W:0] diff;
        diff = {1'b0, a} - {1'b0, b};
        if (diff[MODSUB_W]) begin
            diff = diff + {1'b0, n};
        end
        return diff[MODSUB_W-1:0];
    endfunction

endpackage

// File: rtl/chaos_loader_ctrl_if.sv
// Command/response handshake bundle between the register front-end and the loader.
interface chaos_loader_ctrl_if #(
    parameter int unsigned ADDRW    = 9,
    parameter int unsigned CELLBITS = 32
) ();

    logic                cmd_valid;
    logic                cmd_ready;
    logic [1:0]          cmd_op;
    logic [ADDRW-1:0]    cmd_addr;
    logic [CELLBITS-1:0] cmd_data;
    logic                rsp_valid;
    logic                rsp_ready;
    logic [CELLBITS-1:0] rsp_data;
    logic                rsp_err;

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_err
    );

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_data, rsp_ready,
        output cmd_ready, rsp_valid, rsp_data, rsp_err
    );

endinterface

// File: rtl/chaos_loader_cnt.sv
// Loadable down-counter for chain shift lengths; tc flags the final shift (count == 1).
module chaos_loader_cnt #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         tc
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    // Load has priority over decrement; the count saturates at zero.
    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - W'(1);
        end
    end

    // Count register.
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign tc = (count_q == W'(1));

endmodule

// File: rtl/chaos_loader_ctrl.sv
// Sequencer for the chaos automaton's closed-loop configuration chain: seeks,
// transfers and restores by rotating the chain, tracking the rotation offset.
// Optional macro CHAOS_LOADER_READBACK_EN: WRITE also returns the old cell value.
module chaos_loader_ctrl
    import chaos_loader_pkg::*;
#(
    parameter int unsigned NCELLS   = 400,
    parameter int unsigned CELLBITS = 32,
    parameter int unsigned ADDRW    = 9
) (
    input  logic                 wb_clk_i,
    input  logic                 wb_rst_i,
    chaos_loader_ctrl_if.slave   bus,
    output logic                 busy,
    output logic [ADDRW-1:0]     offset,
    output logic                 shift_en,
    output logic                 shift_out,
    input  logic                 shift_in,
    output logic                 latch
);

    localparam int unsigned CNTW = $clog2(NCELLS * CELLBITS + 1);
    localparam logic [ADDRW:0]   NCELLS_W = (ADDRW + 1)'(NCELLS);
    localparam logic [ADDRW-1:0] LAST_CELL = ADDRW'(NCELLS - 1);

    state_e              state_q, state_d;
    logic [ADDRW-1:0]    offset_q, offset_d;
    logic [1:0]          op_q, op_d;
    logic [ADDRW-1:0]    addr_q, addr_d;
    logic [CELLBITS-1:0] wdata_q, wdata_d;
    logic [CELLBITS-1:0] rdata_q, rdata_d;
    logic                rsp_valid_q, rsp_valid_d;
    logic [CELLBITS-1:0] rsp_data_q, rsp_data_d;
    logic                rsp_err_q, rsp_err_d;

    logic                cnt_load;
    logic [CNTW-1:0]     cnt_load_val;
    logic                cnt_dec;
    logic                cnt_tc;

    logic                cmd_ready;
    logic                accept;
    logic                addr_ok;
    logic [ADDRW-1:0]    seek_k;
    logic [ADDRW-1:0]    restore_k;
    logic [ADDRW-1:0]    next_off;
    logic                xfer_rsp;

    chaos_loader_cnt #(
        .W(CNTW)
    ) u_cnt (
        .clk      (wb_clk_i),
        .rst      (wb_rst_i),
        .load     (cnt_load),
        .load_val (cnt_load_val),
        .dec      (cnt_dec),
        .tc       (cnt_tc)
    );

    assign cmd_ready = (state_q == ST_IDLE) && !rsp_valid_q;
    assign accept    = bus.cmd_valid && cmd_ready;
    assign addr_ok   = ({1'b0, bus.cmd_addr} < NCELLS_W);
    assign seek_k    = ADDRW'(modsub(MODSUB_W'(bus.cmd_addr), MODSUB_W'(offset_q), MODSUB_W'(NCELLS)));
    assign restore_k = ADDRW'(modsub('0, MODSUB_W'(offset_q), MODSUB_W'(NCELLS)));
    assign next_off  = (addr_q == LAST_CELL) ? '0 : addr_q + ADDRW'(1);

`ifdef CHAOS_LOADER_READBACK_EN
    assign xfer_rsp = (op_q == OP_READ) || (op_q == OP_WRITE);
`else
    assign xfer_rsp = (op_q == OP_READ);
`endif

    // Next-state, counter control, chain drive and response bookkeeping.
    always_comb begin
        state_d      = state_q;
        offset_d     = offset_q;
        op_d         = op_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        rdata_d      = rdata_q;
        rsp_valid_d  = rsp_valid_q;
        rsp_data_d   = rsp_data_q;
        rsp_err_d    = rsp_err_q;
        cnt_load     = 1'b0;
        cnt_load_val = '0;
        cnt_dec      = 1'b0;
        shift_en     = 1'b0;
        shift_out    = 1'b0;
        latch        = 1'b0;

        if (rsp_valid_q && bus.rsp_ready) begin
            rsp_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (accept) begin
                    op_d    = bus.cmd_op;
                    addr_d  = bus.cmd_addr;
                    wdata_d = bus.cmd_data;
                    case (bus.cmd_op)
                        OP_READ, OP_WRITE: begin
                            if (!addr_ok) begin
                                rsp_valid_d = 1'b1;
                                rsp_err_d   = 1'b1;
                                rsp_data_d  = '0;
                            end else if (seek_k != '0) begin
                                state_d      = ST_SEEK;
                                cnt_load     = 1'b1;
                                cnt_load_val = CNTW'(seek_k) * CNTW'(CELLBITS);
                            end else begin
                                state_d      = ST_XFER;
                                cnt_load     = 1'b1;
                                cnt_load_val = CNTW'(CELLBITS);
                            end
                        end
                        OP_FINISH: begin
                            if (restore_k != '0) begin
                                state_d      = ST_RESTORE;
                                cnt_load     = 1'b1;
                                cnt_load_val = CNTW'(restore_k) * CNTW'(CELLBITS);
                            end else begin
                                state_d = ST_LATCH;
                            end
                        end
                        default: ;
                    endcase
                end
            end

            ST_SEEK: begin
                shift_en  = 1'b1;
                shift_out = shift_in;
                cnt_dec   = 1'b1;
                if (cnt_tc) begin
                    // Target cell is now at the chain tail.
                    state_d      = ST_XFER;
                    offset_d     = addr_q;
                    cnt_load     = 1'b1;
                    cnt_load_val = CNTW'(CELLBITS);
                end
            end

            ST_XFER: begin
                shift_en = 1'b1;
                cnt_dec  = 1'b1;
                rdata_d  = {rdata_q[CELLBITS-2:0], shift_in};
                if (op_q == OP_WRITE) begin
                    shift_out = wdata_q[CELLBITS-1];
                    wdata_d   = {wdata_q[CELLBITS-2:0], 1'b0};
                end else begin
                    shift_out = shift_in;
                end
                if (cnt_tc) begin
                    state_d  = ST_IDLE;
                    offset_d = next_off;
                    if (xfer_rsp) begin
                        rsp_valid_d = 1'b1;
                        rsp_err_d   = 1'b0;
                        rsp_data_d  = rdata_d;
                    end
                end
            end

            ST_RESTORE: begin
                shift_en  = 1'b1;
                shift_out = shift_in;
                cnt_dec   = 1'b1;
                if (cnt_tc) begin
                    state_d = ST_LATCH;
                end
            end

            ST_LATCH: begin
                latch    = 1'b1;
                offset_d = '0;
                state_d  = ST_IDLE;
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers; reset drops any pending response.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q     <= ST_IDLE;
            offset_q    <= '0;
            op_q        <= '0;
            addr_q      <= '0;
            wdata_q     <= '0;
            rdata_q     <= '0;
            rsp_valid_q <= 1'b0;
            rsp_data_q  <= '0;
            rsp_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            offset_q    <= offset_d;
            op_q        <= op_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            rdata_q     <= rdata_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_data_q  <= rsp_data_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign bus.cmd_ready = cmd_ready;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_err   = rsp_err_q;
    assign busy          = (state_q != ST_IDLE);
    assign offset        = offset_q;

endmodule

// File: tb/tb_chaos_loader_ctrl.sv
// Bench for chaos_loader_ctrl with a 4-cell x 8-bit loop chain.
module tb_chaos_loader_ctrl;

    localparam int unsigned N  = 4;
    localparam int unsigned CB = 8;
    localparam int unsigned AW = 3;

`ifdef CHAOS_LOADER_READBACK_EN
    localparam bit READBACK = 1'b1;
`else
    localparam bit READBACK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst;
    logic          busy;
    logic [AW-1:0] offset;
    logic          shift_en;
    logic          shift_out;
    logic          shift_in;
    logic          latch;

    always #5 clk = ~clk;

    chaos_loader_ctrl_if #(.ADDRW(AW), .CELLBITS(CB)) bus ();

    chaos_loader_ctrl #(
        .NCELLS   (N),
        .CELLBITS (CB),
        .ADDRW    (AW)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .bus       (bus),
        .busy      (busy),
        .offset    (offset),
        .shift_en  (shift_en),
        .shift_out (shift_out),
        .shift_in  (shift_in),
        .latch     (latch)
    );

    // Physical loop chain: bit 31 is the tail feeding shift_in.
    logic [N*CB-1:0] chain;
    logic [N*CB-1:0] chain_seed;
    logic            load_chain;

    assign shift_in = chain[N*CB-1];

    always @(posedge clk) begin
        if (load_chain) chain <= chain_seed;
        else if (shift_en) chain <= {chain[N*CB-2:0], shift_out};
    end

    // Reference model: home contents of each cell and the logical offset.
    logic [CB-1:0] m_cells [N];
    int unsigned   m_off;

    int unsigned n_pass  = 0;
    int unsigned n_total = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Cell c sits (c - o) mod N cells from the tail, MSB nearest the tail.
    function automatic logic [CB-1:0] cell_at(input int unsigned c, input int unsigned o);
        int unsigned   pos;
        logic [31:0]   img;
        pos = (c + N - o) % N;
        img = chain;
        return img[31 - CB*pos -: CB];
    endfunction

    // Per-cycle monitor and invariant checks.
    int unsigned   tot_sh  = 0;
    int unsigned   tot_lat = 0;
    bit            mon_en  = 1'b0;
    logic          p_valid = 1'b0;
    logic          p_ready = 1'b0;
    logic [CB-1:0] p_data  = '0;
    logic          p_err   = 1'b0;

    always @(negedge clk) begin
        if (shift_en) tot_sh++;
        if (latch) tot_lat++;
        if (mon_en) begin
            if (latch) chk("latch_with_shift", shift_en, 0);
            if (busy) chk("cmd_ready_while_busy", bus.cmd_ready, 0);
            if (!shift_en) chk("shift_out_gated", shift_out, 0);
            if (p_valid && !p_ready) begin
                chk("rsp_hold_valid", bus.rsp_valid, 1);
                chk("rsp_hold_data", bus.rsp_data, p_data);
                chk("rsp_hold_err", bus.rsp_err, p_err);
            end
        end
        p_valid = mon_en ? bus.rsp_valid : 1'b0;
        p_ready = bus.rsp_ready;
        p_data  = bus.rsp_data;
        p_err   = bus.rsp_err;
    end

    // Results of the last command, for directed literal checks.
    int unsigned   r_sh;
    int unsigned   r_lat;
    logic          r_valid;
    logic [CB-1:0] r_data;
    logic          r_err;

    task automatic consume_rsp();
        @(posedge clk);
        #1 bus.rsp_ready = 1'b1;
        @(posedge clk);
        #1 bus.rsp_ready = 1'b0;
        chk("rsp_cleared", bus.rsp_valid, 0);
    endtask

    task automatic do_cmd(input logic [1:0] op, input int unsigned addr,
                          input logic [CB-1:0] data, input bit consume);
        bit            exp_rsp;
        logic [CB-1:0] exp_data;
        logic          exp_err;
        int unsigned   exp_sh;
        int unsigned   exp_lat;
        int unsigned   k;
        int unsigned   sh0;
        int unsigned   lat0;
        int unsigned   w;
        bit            done;
        exp_rsp = 1'b0; exp_data = '0; exp_err = 1'b0; exp_sh = 0; exp_lat = 0;
        if (op == 2'b00 || op == 2'b01) begin
            if (addr >= N) begin
                exp_rsp = 1'b1;
                exp_err = 1'b1;
            end else begin
                k = (addr + N - m_off) % N;
                exp_sh = (k + 1) * CB;
                if (op == 2'b00 || READBACK) begin
                    exp_rsp  = 1'b1;
                    exp_data = m_cells[addr];
                end
                if (op == 2'b01) m_cells[addr] = data;
                m_off = (addr + 1) % N;
            end
        end else if (op == 2'b10) begin
            exp_sh  = ((N - m_off) % N) * CB;
            exp_lat = 1;
            m_off   = 0;
        end

        @(negedge clk);
        w = 0;
        while (!bus.cmd_ready && w < 100) begin
            @(negedge clk);
            w++;
        end
        chk("cmd_ready_wait", bus.cmd_ready, 1);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = AW'(addr);
        bus.cmd_data  = data;
        sh0  = tot_sh;
        lat0 = tot_lat;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;

        done = 1'b0;
        w = 0;
        while (!done && w < 400) begin
            @(negedge clk);
            w++;
            if (!busy && (!exp_rsp || bus.rsp_valid)) done = 1'b1;
        end
        chk("cmd_completes", done, 1);

        r_sh    = tot_sh - sh0;
        r_lat   = tot_lat - lat0;
        r_valid = bus.rsp_valid;
        r_data  = bus.rsp_data;
        r_err   = bus.rsp_err;
        chk("shift_cycles", r_sh, exp_sh);
        chk("latch_pulses", r_lat, exp_lat);
        chk("offset", offset, m_off);
        chk("rsp_valid", r_valid, exp_rsp);
        if (exp_rsp) begin
            chk("rsp_data", r_data, exp_data);
            chk("rsp_err", r_err, exp_err);
        end
        for (int unsigned c = 0; c < N; c++) begin
            chk("chain_cell", cell_at(c, m_off), m_cells[c]);
        end

        if (consume && bus.rsp_valid) begin
            repeat ($urandom_range(0, 3)) @(posedge clk);
            consume_rsp();
        end
    endtask

    task automatic resync_model();
        m_off = 0;
        for (int unsigned c = 0; c < N; c++) m_cells[c] = cell_at(c, 0);
    endtask

    task automatic pulse_reset();
        mon_en = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_shift_en", shift_en, 0);
        chk("rst_offset", offset, 0);
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_latch", latch, 0);
        resync_model();
        @(posedge clk);
        #1 mon_en = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst           = 1'b1;
        load_chain    = 1'b1;
        chain_seed    = $urandom;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = '0;
        bus.cmd_addr  = '0;
        bus.cmd_data  = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_cmd_ready", bus.cmd_ready, 1);
        chk("reset_rsp_valid", bus.rsp_valid, 0);
        chk("reset_rsp_data", bus.rsp_data, 0);
        chk("reset_rsp_err", bus.rsp_err, 0);
        chk("reset_busy", busy, 0);
        chk("reset_offset", offset, 0);
        chk("reset_shift_en", shift_en, 0);
        chk("reset_shift_out", shift_out, 0);
        chk("reset_latch", latch, 0);
        rst        = 1'b0;
        load_chain = 1'b0;
        resync_model();
        mon_en = 1'b1;

        // Write to cell 2 from offset 0: seek 2 cells plus the transfer.
        do_cmd(2'b01, 2, 8'hA5, 1'b1);
        chk("w2_shifts", r_sh, 24);
        chk("w2_offset", offset, 3);
        chk("w2_cell2", cell_at(2, 3), 8'hA5);

        do_cmd(2'b01, 0, 8'h12, 1'b1);
        do_cmd(2'b01, 1, 8'h56, 1'b1);
        do_cmd(2'b01, 2, 8'h9A, 1'b1);
        do_cmd(2'b01, 3, 8'hDE, 1'b1);
        do_cmd(2'b00, 1, 8'h00, 1'b1);
        chk("rd1_data", r_data, 8'h56);
        chk("rd1_err", r_err, 0);
        chk("rd1_offset", offset, 2);

        // Bring offset to 3, then FINISH rotates one cell home.
        do_cmd(2'b00, 2, 8'h00, 1'b1);
        chk("rd2_data", r_data, 8'h9A);
        do_cmd(2'b10, 0, 8'h00, 1'b1);
        chk("fin_shifts", r_sh, 8);
        chk("fin_latch", r_lat, 1);
        chk("fin_offset", offset, 0);
        chk("fin_chain", chain, 32'h12569ADE);

        do_cmd(2'b00, 0, 8'h00, 1'b1);
        chk("rd0_shifts", r_sh, 8);
        chk("rd0_data", r_data, 8'h12);
        do_cmd(2'b00, 3, 8'h00, 1'b1);
        chk("rd3_shifts", r_sh, 24);
        chk("rd3_data", r_data, 8'hDE);
        chk("rd3_offset_wrap", offset, 0);
        do_cmd(2'b00, 2, 8'h00, 1'b1);
        do_cmd(2'b00, 1, 8'h00, 1'b1);
        chk("rd1_wrap_shifts", r_sh, 24);
        chk("rd1_wrap_data", r_data, 8'h56);

        // Bad address: immediate error response, held while not consumed.
        do_cmd(2'b00, 5, 8'h00, 1'b0);
        chk("bad_shifts", r_sh, 0);
        chk("bad_err", r_err, 1);
        chk("bad_data", r_data, 0);
        chk("bad_offset", offset, 2);
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bad_hold_valid", bus.rsp_valid, 1);
            chk("bad_hold_err", bus.rsp_err, 1);
            chk("bad_hold_data", bus.rsp_data, 0);
            chk("bad_hold_cmd_ready", bus.cmd_ready, 0);
        end
        consume_rsp();

        do_cmd(2'b11, 1, 8'hFF, 1'b1);
        do_cmd(2'b10, 0, 8'h00, 1'b1);
        chk("fin2_shifts", r_sh, 16);
        do_cmd(2'b10, 0, 8'h00, 1'b1);
        chk("fin0_shifts", r_sh, 0);
        chk("fin0_latch", r_lat, 1);

        for (int i = 0; i < 80; i++) begin
            do_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 5), 8'($urandom), 1'b1);
        end

        // Reset in the middle of a 3-cell seek.
        @(negedge clk);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = AW'((m_off + 3) % N);
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (4) @(negedge clk);
        chk("mid_seek_busy", busy, 1);
        chk("mid_seek_shift", shift_en, 1);
        pulse_reset();

        // A pending response is dropped by reset.
        do_cmd(2'b01, 6, 8'h00, 1'b0);
        chk("pending_before_rst", bus.rsp_valid, 1);
        pulse_reset();

        do_cmd(2'b01, 0, 8'h11, 1'b1);
        do_cmd(2'b01, 1, 8'h22, 1'b1);
        do_cmd(2'b01, 2, 8'h33, 1'b1);
        do_cmd(2'b01, 3, 8'h44, 1'b1);
        do_cmd(2'b10, 0, 8'h00, 1'b1);
        chk("reload_chain", chain, 32'h11223344);

        do_cmd(2'b01, 1, 8'h5A, 1'b1);
`ifdef CHAOS_LOADER_READBACK_EN
        chk("readback_valid", r_valid, 1);
        chk("readback_data", r_data, 8'h22);
`else
        chk("write_no_rsp", r_valid, 0);
`endif

        for (int i = 0; i < 30; i++) begin
            do_cmd(2'($urandom_range(0, 3)), $urandom_range(0, 4), 8'($urandom), 1'b1);
        end
        do_cmd(2'b10, 0, 8'h00, 1'b1);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
